bcd_counter_display: RTL

//  Parametrised N-digit BCD up/down counter driving a multiplexed, common-anode
//  7-segment display (Basys3 class). Successor to the fixed 4-digit free-running

---
 rtl/bcd_counter_display_pkg.sv | 44 ++++
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_counter_display.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd_counter_display_pkg.sv
// Shared definitions for the BCD counter/display slice: active-low segment
// encodings, a counter-width helper and the BCD-to-segment decoder.
package bcd_counter_display_pkg;

   typedef logic [6:0] seg_t;

   // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment on a common-anode display.
   localparam seg_t SEG_0     = 7'b0000001;
   localparam seg_t SEG_1     = 7'b1001111;
   localparam seg_t SEG_2     = 7'b0010010;
   localparam seg_t SEG_3     = 7'b0000110;
   localparam seg_t SEG_4     = 7'b1001100;
   localparam seg_t SEG_5     = 7'b0100100;
   localparam seg_t SEG_6     = 7'b0100000;
   localparam seg_t SEG_7     = 7'b0001111;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0000100;
   localparam seg_t SEG_BLANK = 7'h7F;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int cntWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic seg_t segDecode(input logic [3:0] d);
      seg_t s;
      s = SEG_BLANK;
      case (d)
         4'd0: s = SEG_0;
         4'd1: s = SEG_1;
         4'd2: s = SEG_2;
         4'd3: s = SEG_3;
         4'd4: s = SEG_4;
         4'd5: s = SEG_5;
         4'd6: s = SEG_6;
         4'd7: s = SEG_7;
         4'd8: s = SEG_8;
         4'd9: s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps up or down on request, loads a sanitised value and
// reports a combinational carry/borrow so a chain ripples in a single cycle.
module bcd_digit
   import bcd_counter_display_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       up_dn,
   input  logic       load,
   input  logic [3:0] ld_val,
   output logic [3:0] q,
   output logic       co
);

   logic [3:0] r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= 4'd0;
      end else if (load) begin
         r_q <= (ld_val > 4'd9) ? 4'd0 : ld_val;
      end else if (step) begin
         if (up_dn) begin
            r_q <= (r_q == 4'd9) ? 4'd0 : r_q + 4'd1;
         end else begin
            r_q <= (r_q == 4'd0) ? 4'd9 : r_q - 4'd1;
         end
      end
   end

   assign q  = r_q;
   assign co = step && (up_dn ? (r_q == 4'd9) : (r_q == 4'd0));

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with tick prescaler, wrap pulse and a
// multiplexed common-anode 7-segment driver with optional leading-zero blanking.
module bcd_counter_display
   import bcd_counter_display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 100_000_000,
   parameter int SCAN_DIV = 100_000,
   parameter int BLANK_LZ = 0
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  wrap,
   output logic [6:0]            LED_out,
   output logic [DIGITS-1:0]     LED_anode
);

   localparam int TICK_W = cntWidth(TICK_DIV);
   localparam int SCAN_W = cntWidth(SCAN_DIV);
   localparam int IDX_W  = cntWidth(DIGITS);

   logic [TICK_W-1:0] r_tickCnt;
   logic [SCAN_W-1:0] r_scanCnt;
   logic [IDX_W-1:0]  r_scanIdx;
   logic              r_wrap;
   logic [6:0]        r_ledOut;
   logic [DIGITS-1:0] r_anode;

   logic              w_tick;
   logic              w_scanEnd;
   logic [DIGITS:0]   w_carry;
   logic [3:0]        w_digit [DIGITS];
   logic [3:0]        w_selDigit;
   logic              w_selBlank;
   logic              w_zeroAbove;
   logic [DIGITS-1:0] w_anodeNext;

   assign w_tick     = (r_tickCnt == TICK_W'(TICK_DIV - 1));
   assign w_scanEnd  = (r_scanCnt == SCAN_W'(SCAN_DIV - 1));
   assign w_carry[0] = w_tick && en && !load;

   // Load restarts the tick period so a freshly loaded value is shown for a full tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tickCnt <= '0;
      end else if (load || w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + TICK_W'(1);
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk    (clk),
         .rst    (rst),
         .step   (w_carry[i]),
         .up_dn  (up_dn),
         .load   (load),
         .ld_val (load_val[4*i +: 4]),
         .q      (w_digit[i]),
         .co     (w_carry[i+1])
      );
      assign count_bcd[4*i +: 4] = w_digit[i];
   end

   // A carry out of the top digit means the whole counter rolled over.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= !load && w_carry[DIGITS];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scanCnt <= '0;
         r_scanIdx <= '0;
      end else if (w_scanEnd) begin
         r_scanCnt <= '0;
         r_scanIdx <= (r_scanIdx == IDX_W'(DIGITS - 1)) ? '0 : r_scanIdx + IDX_W'(1);
      end else begin
         r_scanCnt <= r_scanCnt + SCAN_W'(1);
      end
   end

   // Walk from the top digit down so w_zeroAbove covers the addressed digit and all above it.
   always_comb begin
      w_selDigit  = 4'd0;
      w_selBlank  = 1'b0;
      w_anodeNext = '1;
      w_zeroAbove = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zeroAbove = w_zeroAbove && (w_digit[i] == 4'd0);
         if (r_scanIdx == IDX_W'(i)) begin
            w_selDigit     = w_digit[i];
            w_selBlank     = (BLANK_LZ != 0) && (i != 0) && w_zeroAbove;
            w_anodeNext[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ledOut <= SEG_BLANK;
         r_anode  <= '1;
      end else begin
         r_ledOut <= w_selBlank ? SEG_BLANK : segDecode(w_selDigit);
         r_anode  <= w_anodeNext;
      end
   end

   assign wrap      = r_wrap;
   assign LED_out   = r_ledOut;
   assign LED_anode = r_anode;

endmodule
